hazard_forwarding_scoreboard: RTL

//  Parametrised next-generation hazard/forwarding unit at the ID stage of the 5-stage MIPS pipeline.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/md_busy_tracker.sv | 59 +++++
 rtl/hazard_forwarding_scoreboard.sv | 110 +++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the ID-stage hazard/forwarding unit.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam logic [1:0] HZ_NONE = 2'b00;
    localparam logic [1:0] HZ_LOAD = 2'b01;
    localparam logic [1:0] HZ_MD   = 2'b10;
    localparam logic [1:0] HZ_FWD  = 2'b11;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/md_busy_tracker.sv
// Tracks occupancy and destination of the single multi-cycle (mult/div) unit.
//   state   | meaning
//   MD_IDLE | unit free, accepts an issue
//   MD_BUSY | op in flight; cnt counts down to the writeback cycle (cnt==0)
module md_busy_tracker
    import hazard_pkg::*;
#(
    parameter int AW     = 5,
    parameter int MD_LAT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] start_dest,
    output logic          busy,
    output logic [AW-1:0] dest
);

    localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

    md_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [AW-1:0] dest_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= MD_IDLE;
            cnt   <= '0;
            dest  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dest  <= dest_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dest_nxt  = dest;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    state_nxt = MD_BUSY;
                    cnt_nxt   = CW'(MD_LAT - 1);
                    dest_nxt  = start_dest;
                end
            end
            MD_BUSY: begin
                if (cnt == '0) state_nxt = MD_IDLE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

    assign busy = (state == MD_BUSY);

endmodule

// File: rtl/hazard_forwarding_scoreboard.sv
// ID-stage forwarding select, load-use / multi-cycle stall control and stall counter.
module hazard_forwarding_scoreboard
    import hazard_pkg::*;
#(
    parameter int AW     = 5,
    parameter int NSRC   = 2,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NSRC*AW-1:0]   id_src,
    input  logic [NSRC-1:0]      id_src_used,
    input  logic [AW-1:0]        ex_destination,
    input  logic [AW-1:0]        mem_destination,
    input  logic [AW-1:0]        wb_destination,
    input  logic                 ex_rf_enable,
    input  logic                 mem_rf_enable,
    input  logic                 wb_rf_enable,
    input  logic                 ex_load_instruction,
    input  logic                 id_md_start,
    input  logic [AW-1:0]        id_md_dest,
    input  logic                 flush,
    output logic [NSRC*2-1:0]    fwd_sel,
    output logic                 load_enable,
    output logic                 pc_enable,
    output logic                 nop_signal,
    output logic [1:0]           hazard_type,
    output logic                 md_busy,
    output logic [CNT_W-1:0]     stall_count
);

    logic [NSRC*2-1:0] fwd_raw;
    logic [NSRC-1:0]   load_hit;
    logic [NSRC-1:0]   md_hit;
    logic              md_busy_int;
    logic [AW-1:0]     md_dest;
    logic              load_use, md_stall, stall;

    // A zero source never matches anything, which also covers md_dest==0.
    for (genvar i = 0; i < NSRC; i++) begin : g_src
        logic [AW-1:0] src;
        logic          active, ex_hit, mem_hit, wb_hit;

        assign src     = id_src[i*AW +: AW];
        assign active  = id_src_used[i] && (src != '0);
        assign ex_hit  = active && ex_rf_enable  && (src == ex_destination);
        assign mem_hit = active && mem_rf_enable && (src == mem_destination);
        assign wb_hit  = active && wb_rf_enable  && (src == wb_destination);

        assign fwd_raw[i*2 +: 2] = ex_hit  ? FWD_EX  :
                                   mem_hit ? FWD_MEM :
                                   wb_hit  ? FWD_WB  : FWD_RF;
        assign load_hit[i] = ex_hit && ex_load_instruction;
        assign md_hit[i]   = active && md_busy_int && (src == md_dest);
    end

    assign load_use = |load_hit;
    assign md_stall = md_busy_int && ((|md_hit) || id_md_start);
    assign stall    = !flush && (load_use || md_stall);

    md_busy_tracker #(
        .AW     (AW),
        .MD_LAT (MD_LAT)
    ) u_md_busy_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (id_md_start && !flush && !stall),
        .start_dest (id_md_dest),
        .busy       (md_busy_int),
        .dest       (md_dest)
    );

    always_comb begin
        fwd_sel     = fwd_raw;
        load_enable = 1'b1;
        pc_enable   = 1'b1;
        nop_signal  = 1'b0;
        hazard_type = HZ_NONE;
        md_busy     = md_busy_int;
        if (!rst_n) begin
            fwd_sel    = '0;
            nop_signal = 1'b1;
            md_busy    = 1'b0;
        end else if (flush) begin
            fwd_sel    = '0;
            nop_signal = 1'b1;
        end else if (load_use) begin
            load_enable = 1'b0;
            pc_enable   = 1'b0;
            nop_signal  = 1'b1;
            hazard_type = HZ_LOAD;
        end else if (md_stall) begin
            load_enable = 1'b0;
            pc_enable   = 1'b0;
            nop_signal  = 1'b1;
            hazard_type = HZ_MD;
        end else if (|fwd_raw) begin
            hazard_type = HZ_FWD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_count <= '0;
        else if (!pc_enable && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
    end

endmodule
